v2f_arith_eval: RTL and testbench
=================================

Name: v2f_arith_eval

Overview:
- Cycle-level evaluation model of the Factorio arithmetic combinator that the v2f_* mapped cells target.
- Takes a combinator opcode and two 32-bit signed signal values and produces the combinator's output value with Factorio integer semantics.
- Used by the netlist simulator and by the equivalence bench to check mapped designs against their Verilog source.
- Single-cycle ops complete immediately; div/mod/pow run iteratively behind a valid/ready handshake.

Parameters:
- ITERS, 32, iteration count for the div/mod/pow engine; legal values 1..32; fixed at 32 for full 32-bit operands.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_op  input  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 pow, 6 shl, 7 shr, 8 and, 9 or, 10 xor; 11-15 illegal
- in_a  input  32  left operand, signed two's complement
- in_b  input  32  right operand, signed two's complement
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_y  output  32  result, signed
- out_err  output  1  request used an illegal opcode; qualified by out_valid

Behaviour:
- Reset: asynchronous assert while rst_n=0 and synchronous release.
  - Reset values: state IDLE, in_ready=1, out_valid=0, out_y=0, out_err=0.
  - Reset during CALC or DONE aborts the operation; no partial result is ever presented.
- States: IDLE, CALC, DONE.
  - in_ready=1 only in IDLE.
  - A request is accepted on a clk edge where in_valid & in_ready; in_op, in_a and in_b are captured on that edge.
- IDLE -> DONE for ops 0-2 and 6-11+.
  - The result is registered on the accept edge, so out_valid=1 the next cycle (latency 1).
- IDLE -> CALC for ops 3, 4 and 5. The iteration counter loads ITERS-1.
  - CALC decrements the counter once per cycle; it moves to DONE when the counter reaches 0.
  - out_valid goes high ITERS+1 cycles after accept (33 at the default).
- DONE: out_valid=1; out_y and out_err are held stable until out_ready=1. DONE -> IDLE on out_valid & out_ready.
- No new request is accepted in the handoff cycle; back-to-back throughput for single-cycle ops is 1 op per 2 cycles.
- Arithmetic: every result is wrapped to 32 bits and never saturates.
  - add, sub, mul: low 32 bits of the exact result.
  - div: truncate toward zero; B=0 gives 0. INT_MIN/-1 gives INT_MIN.
  - mod: sign follows A (C remainder); B=0 gives 0. INT_MIN % -1 gives 0.
  - Engine for div/mod: restoring division on magnitudes, 1 quotient bit per cycle, sign fixup applied when entering DONE.
  - pow: square-and-multiply on B bits, LSB first, 1 bit per cycle, wrapping multiply.
    - B<0 gives 0. B=0 gives 1, including 0^0.
  - shl: A << (B & 31). shr: arithmetic right shift A >>> (B & 31).
  - and, or, xor: bitwise on 32 bits.
  - Illegal opcode: out_y=0, out_err=1, latency 1.
- in_valid asserted while in_ready=0 is ignored; the source must hold the request.

Optional Feature:
- V2F_EVAL_EARLY_EXIT_EN: for pow only, CALC exits when the remaining unprocessed exponent bits are all zero.
  - With the macro: pow latency = 1 + max(1, bitlen(B)); B<0 takes 1 cycle in CALC.
  - Without the macro: pow always takes ITERS+1 cycles.
  - div/mod latency is unaffected in both cases.

Test Plan:
- add 0x7FFFFFFF + 1 -> out_y=0x80000000, out_valid exactly 1 cycle after accept, out_err=0; sub 0 - 1 -> 0xFFFFFFFF.
- div -7/2 -> -3; mod -7 % 2 -> -1; div 5/0 -> 0; mod 5 % 0 -> 0; each with out_valid 33 cycles after accept (ITERS=32).
- pow 3^4 -> 81; 2^31 -> 0x80000000; 2^-1 -> 0; 0^0 -> 1. Latency is 33 without the macro; with it, 3^4 takes 4 cycles.
- shl 1,33 -> 2; shr -8,1 -> -4; xor 0xF0F0F0F0, 0xFFFFFFFF -> 0x0F0F0F0F; op 13 -> out_y=0, out_err=1.
- Backpressure: out_ready=0 for 5 cycles after a mul 6*7 -> out_y=42 held stable, in_ready=0 throughout; accepted on the first out_ready=1 edge, then in_ready=1 the next cycle.
- rst_n pulsed low 10 cycles into a div -> out_valid=0 and in_ready=1 immediately; the next request, add 2+2, returns 4 with latency 1.

Source files
------------

// File: rtl/v2f_arith_eval.sv
// Factorio arithmetic combinator evaluation model: single-cycle ALU ops plus an iterative
// div/mod/pow engine. Define V2F_EVAL_EARLY_EXIT_EN to let pow leave CALC once the exponent runs out.
`timescale 1ns/1ps
module v2f_arith_eval #(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_y,
   output logic        out_err
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and a DONE result holds until taken.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4;
   localparam logic [3:0] OP_POW = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_AND = 4'd8;
   localparam logic [3:0] OP_OR  = 4'd9;
   localparam logic [3:0] OP_XOR = 4'd10;

   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      rem_q, rem_d;
   logic [31:0]      base_q, base_d;
   logic [31:0]      exp_q, exp_d;
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic             b_zero_q, b_zero_d;
   logic [31:0]      y_q, y_d;
   logic             err_q, err_d;

   logic [31:0] alu_y;
   logic        alu_err;
   logic [31:0] a_mag, b_mag;
   logic [32:0] rem_sh;
   logic        calc_last;

   assign a_mag = in_a[31] ? (~in_a + 32'd1) : in_a;
   assign b_mag = in_b[31] ? (~in_b + 32'd1) : in_b;

   always_comb begin
      alu_y   = '0;
      alu_err = 1'b0;
      case (in_op)
         OP_ADD:                 alu_y = in_a + in_b;
         OP_SUB:                 alu_y = in_a - in_b;
         OP_MUL:                 alu_y = in_a * in_b;
         OP_SHL:                 alu_y = in_a << in_b[4:0];
         OP_SHR:                 alu_y = $signed(in_a) >>> in_b[4:0];
         OP_AND:                 alu_y = in_a & in_b;
         OP_OR:                  alu_y = in_a | in_b;
         OP_XOR:                 alu_y = in_a ^ in_b;
         OP_DIV, OP_MOD, OP_POW: alu_y = '0;
         default:                alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      base_d    = base_q;
      exp_d     = exp_q;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      b_zero_d  = b_zero_q;
      y_d       = y_q;
      err_d     = err_q;
      rem_sh    = '0;
      calc_last = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d     = in_op;
               a_neg_d  = in_a[31];
               b_neg_d  = in_b[31];
               b_zero_d = (in_b == 32'd0);
               cnt_d    = CNT_LOAD;
               case (in_op)
                  OP_DIV, OP_MOD: begin
                     acc_d   = a_mag;
                     rem_d   = '0;
                     base_d  = b_mag;
                     state_d = ST_CALC;
                  end
                  OP_POW: begin
                     acc_d   = 32'd1;
                     base_d  = in_a;
                     exp_d   = in_b;
                     state_d = ST_CALC;
                  end
                  default: begin
                     y_d     = alu_y;
                     err_d   = alu_err;
                     state_d = ST_DONE;
                  end
               endcase
            end
         end
         ST_CALC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_POW) begin
               if (exp_q[0]) acc_d = acc_q * base_q;
               base_d = base_q * base_q;
               exp_d  = exp_q >> 1;
`ifdef V2F_EVAL_EARLY_EXIT_EN
               calc_last = (cnt_q == '0) || (exp_q[31:1] == 31'd0) || b_neg_q;
`else
               calc_last = (cnt_q == '0);
`endif
            end else begin
               // Restoring division: dividend magnitude shifts out of acc into rem, quotient bits shift in.
               rem_sh = {rem_q, acc_q[31]};
               if (rem_sh >= {1'b0, base_q}) begin
                  rem_d = rem_sh[31:0] - base_q;
                  acc_d = {acc_q[30:0], 1'b1};
               end else begin
                  rem_d = rem_sh[31:0];
                  acc_d = {acc_q[30:0], 1'b0};
               end
               calc_last = (cnt_q == '0);
            end
            if (calc_last) begin
               state_d = ST_DONE;
               err_d   = 1'b0;
               if (op_q == OP_POW)
                  y_d = b_neg_q ? 32'd0 : acc_d;
               else if (b_zero_q)
                  y_d = 32'd0;
               else if (op_q == OP_DIV)
                  y_d = (a_neg_q ^ b_neg_q) ? (~acc_d + 32'd1) : acc_d;
               else
                  y_d = a_neg_q ? (~rem_d + 32'd1) : rem_d;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         base_q   <= '0;
         exp_q    <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         y_q      <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         b_zero_q <= b_zero_d;
         y_q      <= y_d;
         err_q    <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_y     = y_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_v2f_arith_eval.sv
// Directed table-driven bench for v2f_arith_eval, including backpressure and mid-operation reset.
`timescale 1ns/1ps
module tb_v2f_arith_eval;

`ifdef V2F_EVAL_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = '0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_y;
   logic        out_err;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        err;
      int          lat;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   v2f_arith_eval #(.ITERS(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endtask

   function automatic void add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] y, input logic err, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.y = y; v.err = err; v.lat = lat;
      vecs.push_back(v);
   endfunction

   // Called at a falling edge; returns at the falling edge where out_valid was first seen.
   task automatic run_req(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] y, input logic err, input int lat);
      int guard;
      int l;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({name, "_rdy"}, {31'd0, in_ready}, 32'd1);
      if (!in_ready) begin
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(y);
      @(posedge clk);
      #1 in_valid = 1'b0;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!out_valid && l < 200);
      check({name, "_lat"}, 32'(l), 32'(lat));
      check({name, "_y"}, out_y, exp_q.pop_front());
      check({name, "_err"}, {31'd0, out_err}, {31'd0, err});
   endtask

   initial begin
      add_vec(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
      add_vec(4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
      add_vec(4'd2,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b0, 1);
      add_vec(4'd2,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1);
      add_vec(4'd3,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33);
      add_vec(4'd4,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33);
      add_vec(4'd3,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 33);
      add_vec(4'd4,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 33);
      add_vec(4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
      add_vec(4'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33);
      add_vec(4'd3,  32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
      add_vec(4'd4,  32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 33);
      add_vec(4'd5,  32'h0000_0003, 32'h0000_0004, 32'h0000_0051, 1'b0, EARLY ? 4 : 33);
      add_vec(4'd5,  32'h0000_0002, 32'h0000_001F, 32'h8000_0000, 1'b0, EARLY ? 6 : 33);
      add_vec(4'd5,  32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, EARLY ? 2 : 33);
      add_vec(4'd5,  32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, EARLY ? 2 : 33);
      add_vec(4'd5,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFF8, 1'b0, EARLY ? 3 : 33);
      add_vec(4'd6,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1);
      add_vec(4'd7,  32'hFFFF_FFF8, 32'h0000_0001, 32'hFFFF_FFFC, 1'b0, 1);
      add_vec(4'd8,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1);
      add_vec(4'd9,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1);
      add_vec(4'd10, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 1);
      add_vec(4'd13, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
      add_vec(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);

      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_y", out_y, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++)
         run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].err,
                 vecs[i].lat);

      // Backpressure: result must stay put while the consumer stalls.
      @(negedge clk);
      out_ready = 1'b0;
      run_req("bp_mul", 4'd2, 32'd6, 32'd7, 32'd42, 1'b0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp_hold_y%0d", i), out_y, 32'd42);
         check($sformatf("bp_hold_rdy%0d", i), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_rdy", {31'd0, in_ready}, 32'd1);

      // Reset ten cycles into a division.
      in_valid = 1'b1;
      in_op    = 4'd3;
      in_a     = 32'd100;
      in_b     = 32'd7;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_div_busy", {31'd0, in_ready}, 32'd0);
      check("mid_div_valid", {31'd0, out_valid}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_rdy", {31'd0, in_ready}, 32'd1);
      check("arst_y", out_y, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_req("post_rst_add", 4'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
